// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer: state encoding,
// LFSR constants and a constant-time clog2 helper.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GO    = 3'd2,
        ST_SHOW  = 3'd3,
        ST_FAULT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 counted from the output end (bit 0).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int clog2(input longint value);
        int result;
        result = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'sd1 <<< i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_DIV clocks,
// restartable through a synchronous clear.
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW_RAW = clog2(longint'(CLK_DIV));
    localparam int CW     = (CW_RAW > 0) ? CW_RAW : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time engine: random go delay, false-start detection,
// timeout, multi-run session and best-score tracking.
module reaction_timer_core
    import reaction_pkg::*;
#(
    parameter int CLK_DIV         = 50000,
    parameter int SCORE_W         = 13,
    parameter int RUNS            = 4,
    parameter int DELAY_MIN_MS    = 1000,
    parameter int DELAY_RAND_BITS = 11,
    localparam int RCW            = clog2(longint'(RUNS) + 1)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               buttonStart,
    input  logic               buttonHit,
    output logic               GreenLed,
    output logic               RedLed,
    output logic [SCORE_W-1:0] Score,
    output logic [SCORE_W-1:0] BestScore,
    output logic [RCW-1:0]     RunCount,
    output logic               ScoreValid,
    output logic               FalseStart,
    output logic [2:0]         State
);

    localparam int DW_RAW = clog2(longint'(DELAY_MIN_MS)
                                  + (longint'(1) << DELAY_RAND_BITS));
    localparam int DW     = (DW_RAW > 0) ? DW_RAW : 1;

    logic               r_start_prev;
    logic               r_hit_prev;
    logic               r_start_ev;
    logic               r_hit_ev;
    logic [15:0]        r_lfsr;
    state_t             r_state;
    logic [DW-1:0]      r_delay;
    logic [SCORE_W-1:0] r_cnt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_best;
    logic [RCW-1:0]     r_runs;
    logic               r_valid;
    logic               r_green;
    logic               r_red;
    logic               r_fault;

    state_t             w_next;
    logic               w_load;
    logic               w_record;
    logic               w_session_clr;
    logic               w_clr;
    logic               w_tick;
    logic               w_fb;
    logic               w_cnt_max;

    assign w_fb      = ^(r_lfsr & LFSR_TAPS);
    assign w_cnt_max = &r_cnt;

    ms_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .i_clk (Clock),
        .i_rst (Reset),
        .i_clr (w_clr),
        .o_tick(w_tick)
    );

    // Events are registered, so the FSM acts two edges after the level rises.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_start_prev <= 1'b0;
            r_hit_prev   <= 1'b0;
            r_start_ev   <= 1'b0;
            r_hit_ev     <= 1'b0;
            r_lfsr       <= LFSR_SEED;
        end else begin
            r_start_prev <= buttonStart;
            r_hit_prev   <= buttonHit;
            r_start_ev   <= buttonStart & ~r_start_prev;
            r_hit_ev     <= buttonHit & ~r_hit_prev;
            r_lfsr       <= {w_fb, r_lfsr[15:1]};
        end
    end

    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_record      = 1'b0;
        w_session_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_start_ev) begin
                    w_load = 1'b1;
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_hit_ev) begin
                    w_next = ST_FAULT;
                end else if (r_delay == '0
                             || (w_tick && r_delay == DW'(1))) begin
                    w_next = ST_GO;
                end
            end
            ST_GO: begin
                if (r_hit_ev || (w_tick && w_cnt_max)) begin
                    w_record = 1'b1;
                    w_next   = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_start_ev) begin
                    if (r_runs == RCW'(RUNS)) begin
                        w_next = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_next = ST_WAIT;
                    end
                end
            end
            ST_FAULT: begin
                if (r_start_ev) begin
                    w_load = 1'b1;
                    w_next = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (r_start_ev) begin
                    w_session_clr = 1'b1;
                    w_next        = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        w_clr = (w_next != r_state)
                && (w_next == ST_WAIT || w_next == ST_GO);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_green <= 1'b0;
            r_red   <= 1'b0;
            r_fault <= 1'b0;
            r_valid <= 1'b0;
            r_delay <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_green <= (w_next == ST_GO);
            r_red   <= (w_next == ST_WAIT) || (w_next == ST_FAULT);
            r_fault <= (w_next == ST_FAULT);
            r_valid <= w_record;
            if (w_load) begin
                r_delay <= DW'(DELAY_MIN_MS)
                           + DW'(r_lfsr[DELAY_RAND_BITS-1:0]);
            end else if (r_state == ST_WAIT && w_tick && r_delay != '0) begin
                r_delay <= r_delay - DW'(1);
            end
            if (w_next == ST_GO && r_state != ST_GO) begin
                r_cnt <= '0;
            end else if (r_state == ST_GO && w_tick && !w_cnt_max) begin
                r_cnt <= r_cnt + SCORE_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_score <= '0;
            r_best  <= '1;
            r_runs  <= '0;
        end else if (w_record) begin
            r_score <= r_cnt;
            r_runs  <= r_runs + RCW'(1);
            if (r_cnt < r_best) r_best <= r_cnt;
        end else if (w_session_clr) begin
            r_runs <= '0;
            r_best <= '1;
        end
    end

    assign GreenLed   = r_green;
    assign RedLed     = r_red;
    assign FalseStart = r_fault;
    assign ScoreValid = r_valid;
    assign Score      = r_score;
    assign BestScore  = r_best;
    assign RunCount   = r_runs;
    assign State      = r_state;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Scoreboard bench for reaction_timer_core: timing-level reference
// model predicts every state change; a monitor checks each one.
module tb_reaction_timer_core;

    localparam int CLK_DIV = 4;
    localparam int SCORE_W = 6;
    localparam int RUNS    = 2;
    localparam int DMIN    = 3;
    localparam int DBITS   = 2;
    localparam int SMAX    = 63;

    localparam int S_IDLE  = 0;
    localparam int S_WAIT  = 1;
    localparam int S_GO    = 2;
    localparam int S_SHOW  = 3;
    localparam int S_FAULT = 4;
    localparam int S_DONE  = 5;

    logic               Clock = 1'b0;
    logic               Reset = 1'b0;
    logic               buttonStart = 1'b0;
    logic               buttonHit = 1'b0;
    logic               GreenLed;
    logic               RedLed;
    logic [SCORE_W-1:0] Score;
    logic [SCORE_W-1:0] BestScore;
    logic [1:0]         RunCount;
    logic               ScoreValid;
    logic               FalseStart;
    logic [2:0]         State;

    reaction_timer_core #(
        .CLK_DIV        (CLK_DIV),
        .SCORE_W        (SCORE_W),
        .RUNS           (RUNS),
        .DELAY_MIN_MS   (DMIN),
        .DELAY_RAND_BITS(DBITS)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .buttonStart(buttonStart),
        .buttonHit  (buttonHit),
        .GreenLed   (GreenLed),
        .RedLed     (RedLed),
        .Score      (Score),
        .BestScore  (BestScore),
        .RunCount   (RunCount),
        .ScoreValid (ScoreValid),
        .FalseStart (FalseStart),
        .State      (State)
    );

    always #5 Clock = ~Clock;

    // Edges since reset release; edge n leaves cyc == n.
    int cyc;
    always @(posedge Clock or posedge Reset) begin
        if (Reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int at;
        int st;
        int sv;
        int sc;
        int best;
        int runs;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int m_st = S_IDLE;
    int m_score = 0;
    int m_best = SMAX;
    int m_runs = 0;
    int m_go = 0;

    function automatic void push_exp(int at, int sv);
        exp_t e;
        e.at   = at;
        e.st   = m_st;
        e.sv   = sv;
        e.sc   = m_score;
        e.best = m_best;
        e.runs = m_runs;
        q.push_back(e);
    endfunction

    function automatic logic [15:0] lfsr_at(int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        return l;
    endfunction

    bit         mon_en = 1'b0;
    logic [2:0] prev_st = 3'd0;

    always @(negedge Clock) begin
        if (mon_en && (State != prev_st || ScoreValid)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: state=%0d valid=%0d cycle %0d, none expected",
                         State, ScoreValid, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("event_cycle", cyc, mon_e.at);
                chk("State", int'(State), mon_e.st);
                chk("ScoreValid", int'(ScoreValid), mon_e.sv);
                chk("Score", int'(Score), mon_e.sc);
                chk("BestScore", int'(BestScore), mon_e.best);
                chk("RunCount", int'(RunCount), mon_e.runs);
                chk("GreenLed", int'(GreenLed), int'(mon_e.st == S_GO));
                chk("RedLed", int'(RedLed),
                    int'(mon_e.st == S_WAIT || mon_e.st == S_FAULT));
                chk("FalseStart", int'(FalseStart), int'(mon_e.st == S_FAULT));
            end
        end
        prev_st = State;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge Clock);
    endtask

    task automatic press(input int h, input bit s, input bit hh);
        wait_cyc(h);
        buttonStart = s;
        buttonHit   = hh;
        @(negedge Clock);
        buttonStart = 1'b0;
        buttonHit   = 1'b0;
    endtask

    task automatic do_start();
        int h;
        int a;
        int d;
        bit stray;
        logic [15:0] l;
        h = cyc + int'($urandom_range(0, 3));
        a = h + 2;
        stray = 1'($urandom_range(0, 1));
        press(h, 1'b1, stray);
        if (m_st == S_DONE) begin
            m_runs = 0;
            m_best = SMAX;
            m_st   = S_IDLE;
        end else if (m_st == S_SHOW && m_runs == RUNS) begin
            m_st = S_DONE;
        end else begin
            l    = lfsr_at(a - 1);
            d    = DMIN + int'(l[DBITS-1:0]);
            m_st = S_WAIT;
            m_go = a + CLK_DIV * d;
        end
        push_exp(a, 0);
        wait_cyc(a);
    endtask

    task automatic go_wait();
        m_st = S_GO;
        push_exp(m_go, 0);
    endtask

    task automatic do_hit(input int k, input bit with_start);
        int a;
        if (k > SMAX) begin
            a       = m_go + CLK_DIV * (SMAX + 1);
            m_score = SMAX;
        end else begin
            a = m_go + CLK_DIV * k + int'($urandom_range(1, CLK_DIV));
            press(a - 2, with_start, 1'b1);
            m_score = k;
        end
        m_runs++;
        if (m_score < m_best) m_best = m_score;
        m_st = S_SHOW;
        push_exp(a, 1);
        wait_cyc(a);
    endtask

    task automatic do_false(input bit with_start);
        int a;
        a = int'($urandom_range(unsigned'(cyc + 2), unsigned'(m_go)));
        press(a - 2, with_start, 1'b1);
        m_st = S_FAULT;
        push_exp(a, 0);
        wait_cyc(a);
    endtask

    task automatic reset_check(input string tag);
        mon_en = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk({tag, "_State"}, int'(State), S_IDLE);
        chk({tag, "_GreenLed"}, int'(GreenLed), 0);
        chk({tag, "_RedLed"}, int'(RedLed), 0);
        chk({tag, "_ScoreValid"}, int'(ScoreValid), 0);
        chk({tag, "_FalseStart"}, int'(FalseStart), 0);
        chk({tag, "_Score"}, int'(Score), 0);
        chk({tag, "_BestScore"}, int'(BestScore), SMAX);
        chk({tag, "_RunCount"}, int'(RunCount), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        q.delete();
        m_st    = S_IDLE;
        m_score = 0;
        m_best  = SMAX;
        m_runs  = 0;
        mon_en  = 1'b1;
    endtask

    initial begin
        int k;
        @(negedge Clock);
        reset_check("reset");

        // Hit 5 ticks into GO.
        do_start();
        go_wait();
        do_hit(5, 1'b0);
        // False start, retry, then timeout.
        do_start();
        do_false(1'b0);
        do_start();
        go_wait();
        do_hit(SMAX + 1, 1'b0);
        // Session complete, then cleared.
        do_start();
        do_start();
        // Scores 9 then 5.
        do_start();
        go_wait();
        do_hit(9, 1'b0);
        do_start();
        go_wait();
        do_hit(5, 1'b0);
        do_start();
        do_start();
        // Start and hit together in GO, then reset mid-GO.
        do_start();
        go_wait();
        do_hit(3, 1'b1);
        do_start();
        go_wait();
        wait_cyc(m_go + CLK_DIV * 3);
        reset_check("midgo");

        repeat (40) begin
            case (m_st)
                S_WAIT: begin
                    if ($urandom_range(0, 3) == 0) do_false(1'($urandom_range(0, 1)));
                    else go_wait();
                end
                S_GO: begin
                    k = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 20));
                    do_hit(k, 1'($urandom_range(0, 1)));
                end
                default: do_start();
            endcase
        end
        if (m_st == S_GO) do_hit(2, 1'b0);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge Clock);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected events never seen, required 0", q.size());
        end
        repeat (3) @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
